// File: rtl/enc_8b10b_mem.sv
// ---------------------------------------------------------------------------
// enc_8b10b_mem -- table-driven 8b/10b line encoder (IEEE 802.3 Cl.36 codes).
//
// One symbol per clock, one clock of latency. The 5b/6b and 3b/4b stages are
// small case ROMs holding the RD- column plus two flags per entry:
//   comp : the RD+ form is the bitwise complement of the RD- form
//   flip : the code is unbalanced, so it inverts the running disparity
// D.x.3 and D7 are balanced but still have two forms (comp=1, flip=0).
//
// Compile-time option:
//   ENC8B10B_KCHECK_EN  defined   -> o_KErr flags i_Kin on a byte with no K code
//                       undefined -> o_KErr is held at 0
// In both builds an invalid K request is encoded as the data symbol D.x.y.
// ---------------------------------------------------------------------------
module enc_8b10b_mem #(
    parameter logic pRdInit = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i8_Din,
    input  logic       i_Kin,
    input  logic       i_ForceDisparity,
    input  logic       i_Disparity,
    output logic [9:0] o10_Dout,
    output logic       o_Rd,
    output logic       o_KErr
);

    // ROM entry formats: RD- code word plus the two disparity flags.
    typedef struct packed {
        logic       flip;
        logic       comp;
        logic [5:0] code;
    } sb6_t;

    typedef struct packed {
        logic       flip;
        logic       comp;
        logic [3:0] code;
    } sb4_t;

    logic [4:0] x_val;       // EDCBA
    logic [2:0] y_val;       // HGF
    logic       rd_cur;      // disparity entering this symbol
    logic       valid_k;     // byte is one of the twelve legal K codes
    logic       use_k;       // encode as control symbol
    logic       k_err;
    sb6_t       rom6;
    sb4_t       rom4;
    logic [5:0] code6;
    logic       rd_mid;      // disparity between the 6b and 4b sub-blocks
    logic       use_a7;
    logic [3:0] code4;
    logic       rd_next;

    assign x_val  = i8_Din[4:0];
    assign y_val  = i8_Din[7:5];
    assign rd_cur = i_ForceDisparity ? i_Disparity : o_Rd;

    // Legal control codes: all K28.y, plus K23.7, K27.7, K29.7, K30.7.
    assign valid_k = (x_val == 5'd28) ||
                     ((y_val == 3'd7) && ((x_val == 5'd23) || (x_val == 5'd27) ||
                                          (x_val == 5'd29) || (x_val == 5'd30)));
    assign use_k   = i_Kin && valid_k;

`ifdef ENC8B10B_KCHECK_EN
    assign k_err = i_Kin && !valid_k;
`else
    assign k_err = 1'b0;
`endif

    // 5b/6b ROM: RD- column of abcdei, K28 overrides the D28 entry.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via the default arm) so no latch is inferred.
        unique case (x_val)
            5'd0:    rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b100111};
            5'd1:    rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b011101};
            5'd2:    rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b101101};
            5'd3:    rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b110001};
            5'd4:    rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b110101};
            5'd5:    rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b101001};
            5'd6:    rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b011001};
            5'd7:    rom6 = '{flip: 1'b0, comp: 1'b1, code: 6'b111000};
            5'd8:    rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b111001};
            5'd9:    rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b100101};
            5'd10:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b010101};
            5'd11:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b110100};
            5'd12:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b001101};
            5'd13:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b101100};
            5'd14:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b011100};
            5'd15:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b010111};
            5'd16:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b011011};
            5'd17:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b100011};
            5'd18:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b010011};
            5'd19:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b110010};
            5'd20:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b001011};
            5'd21:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b101010};
            5'd22:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b011010};
            5'd23:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b111010};
            5'd24:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b110011};
            5'd25:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b100110};
            5'd26:   rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b010110};
            5'd27:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b110110};
            5'd28:   rom6 = use_k ? '{flip: 1'b1, comp: 1'b1, code: 6'b001111}
                                  : '{flip: 1'b0, comp: 1'b0, code: 6'b001110};
            5'd29:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b101110};
            5'd30:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b011110};
            5'd31:   rom6 = '{flip: 1'b1, comp: 1'b1, code: 6'b101011};
            default: rom6 = '{flip: 1'b0, comp: 1'b0, code: 6'b000000};
        endcase
    end

    // Select the RD+ form when needed and derive the mid-symbol disparity.
    always_comb begin
        code6  = (rd_cur && rom6.comp) ? ~rom6.code : rom6.code;
        rd_mid = rd_cur ^ rom6.flip;
    end

    // Alternate x.7 form avoids a run of five around the e/i and f/g boundary;
    // every legal K.y.7 also uses it.
    always_comb begin
        use_a7 = 1'b0;
        if (y_val == 3'd7) begin
            if (use_k) begin
                use_a7 = 1'b1;
            end else if (!rd_mid) begin
                use_a7 = (x_val == 5'd17) || (x_val == 5'd18) || (x_val == 5'd20);
            end else begin
                use_a7 = (x_val == 5'd11) || (x_val == 5'd13) || (x_val == 5'd14);
            end
        end
    end

    // 3b/4b ROM: data and control columns (RD- form of fghj).
    always_comb begin
        rom4 = '{flip: 1'b0, comp: 1'b0, code: 4'b0000};
        if (use_a7) begin
            rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b0111};
        end else if (use_k) begin
            unique case (y_val)
                3'd0:    rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b1011};
                3'd1:    rom4 = '{flip: 1'b0, comp: 1'b1, code: 4'b0110};
                3'd2:    rom4 = '{flip: 1'b0, comp: 1'b1, code: 4'b1010};
                3'd3:    rom4 = '{flip: 1'b0, comp: 1'b1, code: 4'b1100};
                3'd4:    rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b1101};
                3'd5:    rom4 = '{flip: 1'b0, comp: 1'b1, code: 4'b0101};
                3'd6:    rom4 = '{flip: 1'b0, comp: 1'b1, code: 4'b1001};
                default: rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b0111};
            endcase
        end else begin
            unique case (y_val)
                3'd0:    rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b1011};
                3'd1:    rom4 = '{flip: 1'b0, comp: 1'b0, code: 4'b1001};
                3'd2:    rom4 = '{flip: 1'b0, comp: 1'b0, code: 4'b0101};
                3'd3:    rom4 = '{flip: 1'b0, comp: 1'b1, code: 4'b1100};
                3'd4:    rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b1101};
                3'd5:    rom4 = '{flip: 1'b0, comp: 1'b0, code: 4'b1010};
                3'd6:    rom4 = '{flip: 1'b0, comp: 1'b0, code: 4'b0110};
                default: rom4 = '{flip: 1'b1, comp: 1'b1, code: 4'b1110};
            endcase
        end
    end

    // Select the RD+ form of fghj and derive the end-of-symbol disparity.
    always_comb begin
        code4   = (rd_mid && rom4.comp) ? ~rom4.code : rom4.code;
        rd_next = rd_mid ^ rom4.flip;
    end

    // Output register: code group, running disparity and K error flag together.
    always_ff @(posedge i_Clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_Rst) begin
            o10_Dout <= 10'h000;
            o_Rd     <= pRdInit;
            o_KErr   <= 1'b0;
        end else begin
            o10_Dout <= {code6, code4};
            o_Rd     <= rd_next;
            o_KErr   <= k_err;
        end
    end

endmodule

// File: tb/tb_enc_8b10b_mem.sv
// ---------------------------------------------------------------------------
// tb_enc_8b10b_mem -- self-checking bench for enc_8b10b_mem.
// Reference model: full two-column code tables, disparity from bit counts.
// ---------------------------------------------------------------------------
module tb_enc_8b10b_mem;

    localparam logic RD_INIT = 1'b0;

    // 5b/6b abcdei, RD- and RD+ columns, data symbols D0..D31.
    localparam logic [5:0] T6N [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [0:31] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    // 3b/4b fghj for data (x.7 is the primary form) and control, RD-/RD+.
    localparam logic [3:0] T4N [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4N [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] K_LIST [0:11] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    logic       i_Clk;
    logic       i_Rst;
    logic [7:0] i8_Din;
    logic       i_Kin;
    logic       i_ForceDisparity;
    logic       i_Disparity;
    logic [9:0] o10_Dout;
    logic       o_Rd;
    logic       o_KErr;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_rd;

    enc_8b10b_mem #(.pRdInit(RD_INIT)) dut (
        .i_Clk            (i_Clk),
        .i_Rst            (i_Rst),
        .i8_Din           (i8_Din),
        .i_Kin            (i_Kin),
        .i_ForceDisparity (i_ForceDisparity),
        .i_Disparity      (i_Disparity),
        .o10_Dout         (o10_Dout),
        .o_Rd             (o_Rd),
        .o_KErr           (o_KErr)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Disparity after a sub-block: more ones -> positive, fewer -> negative.
    function automatic logic rd_after(input int ones, input int half, input logic rd_in);
        if (ones > half) return 1'b1;
        if (ones < half) return 1'b0;
        return rd_in;
    endfunction

    function automatic void enc_ref(input logic [7:0] b, input logic k, input logic rdc,
                                    output logic [9:0] code, output logic rd_out,
                                    output logic kerr);
        int         x;
        int         y;
        logic       vk;
        logic       a7;
        logic       rd6;
        logic [5:0] six;
        logic [3:0] four;
        x  = int'(b[4:0]);
        y  = int'(b[7:5]);
        vk = (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
        if (k && vk && x == 28) six = rdc ? 6'b110000 : 6'b001111;
        else                    six = rdc ? T6P[x] : T6N[x];
        rd6 = rd_after($countones(six), 3, rdc);
        if (k && vk) begin
            four = rd6 ? K4P[y] : K4N[y];
        end else if (y == 7) begin
            a7   = rd6 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20);
            four = a7 ? (rd6 ? 4'b1000 : 4'b0111) : (rd6 ? 4'b0001 : 4'b1110);
        end else begin
            four = rd6 ? T4P[y] : T4N[y];
        end
        rd_out = rd_after($countones(four), 2, rd6);
        code   = {six, four};
`ifdef ENC8B10B_KCHECK_EN
        kerr = k && !vk;
`else
        kerr = 1'b0;
`endif
    endfunction

    function automatic int max_run(input logic [9:0] c);
        int best = 1;
        int cur  = 1;
        for (int i = 1; i < 10; i++) begin
            cur  = (c[i] == c[i-1]) ? cur + 1 : 1;
            best = (cur > best) ? cur : best;
        end
        return best;
    endfunction

    // Apply one symbol, wait one clock, compare against the model.
    task automatic step(input logic [7:0] d, input logic k, input logic f, input logic dp,
                        input string tag);
        logic [9:0] exp_code;
        logic       exp_rd;
        logic       exp_kerr;
        i8_Din           = d;
        i_Kin            = k;
        i_ForceDisparity = f;
        i_Disparity      = dp;
        enc_ref(d, k, f ? dp : model_rd, exp_code, exp_rd, exp_kerr);
        @(posedge i_Clk);
        #1;
        model_rd = exp_rd;
        check({tag, " code"}, 32'(o10_Dout), 32'(exp_code));
        check({tag, " rd"},   32'(o_Rd),     32'(exp_rd));
        check({tag, " kerr"}, 32'(o_KErr),   32'(exp_kerr));
        check({tag, " disp"}, 32'($countones(o10_Dout) >= 4 && $countones(o10_Dout) <= 6), 32'(1));
        check({tag, " run"},  32'(max_run(o10_Dout) <= 5), 32'(1));
    endtask

    // Reset asserted for one edge with random data on the inputs.
    task automatic reset_step(input string tag);
        i_Rst            = 1'b1;
        i8_Din           = 8'($urandom);
        i_Kin            = 1'($urandom);
        i_ForceDisparity = 1'($urandom);
        i_Disparity      = 1'($urandom);
        @(posedge i_Clk);
        #1;
        i_Rst    = 1'b0;
        model_rd = RD_INIT;
        check({tag, " code"}, 32'(o10_Dout), 32'(10'h000));
        check({tag, " rd"},   32'(o_Rd),     32'(RD_INIT));
        check({tag, " kerr"}, 32'(o_KErr),   32'(1'b0));
    endtask

    initial begin
        logic [7:0] b;
        logic       k;
        model_rd = RD_INIT;
        i_Rst = 1'b1; i8_Din = 8'h00; i_Kin = 1'b0; i_ForceDisparity = 1'b0; i_Disparity = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        reset_step("reset");

        // Known code groups.
        step(8'h00, 1'b0, 1'b0, 1'b0, "D0.0");
        check("D0.0 lit", 32'(o10_Dout), 32'(10'h274));
        step(8'hBC, 1'b1, 1'b0, 1'b0, "K28.5-");
        check("K28.5- lit", 32'(o10_Dout), 32'(10'h0FA));
        check("K28.5- rd lit", 32'(o_Rd), 32'(1'b1));
        step(8'hBC, 1'b1, 1'b0, 1'b0, "K28.5+");
        check("K28.5+ lit", 32'(o10_Dout), 32'(10'h305));
        check("K28.5+ rd lit", 32'(o_Rd), 32'(1'b0));
        step(8'hB5, 1'b0, 1'b0, 1'b0, "D21.5-");
        check("D21.5- lit", 32'(o10_Dout), 32'(10'h2AA));
        step(8'hB5, 1'b0, 1'b1, 1'b1, "D21.5 frc+");
        check("D21.5 frc+ lit", 32'(o10_Dout), 32'(10'h2AA));
        check("D21.5 frc+ rd", 32'(o_Rd), 32'(1'b1));
        step(8'hB5, 1'b0, 1'b0, 1'b0, "D21.5+");
        check("D21.5+ lit", 32'(o10_Dout), 32'(10'h2AA));
        step(8'h17, 1'b1, 1'b0, 1'b0, "badK 17");
        check("badK 17 lit", 32'(o10_Dout), 32'(10'h05B));
        step(8'hBC, 1'b1, 1'b0, 1'b0, "K28.5 to RD-");
        check("to RD- lit", 32'(o_Rd), 32'(1'b0));
        step(8'h00, 1'b0, 1'b1, 1'b1, "force+ D0.0");
        check("force+ D0.0 lit", 32'(o10_Dout), 32'(10'h18B));
        step(8'h00, 1'b0, 1'b1, 1'b0, "force- D0.0");
        check("force- D0.0 lit", 32'(o10_Dout), 32'(10'h274));
        step(8'hF1, 1'b0, 1'b1, 1'b0, "D17.7 A7");
        check("D17.7 A7 lit", 32'(o10_Dout), 32'(10'h237));
        step(8'hEB, 1'b0, 1'b1, 1'b1, "D11.7+ A7");
        step(8'hF7, 1'b1, 1'b0, 1'b0, "K23.7");

        // Reset mid-stream discards the pending symbol.
        i8_Din = 8'hBC; i_Kin = 1'b1;
        reset_step("mid reset");
        step(8'h00, 1'b0, 1'b0, 1'b0, "post reset D0.0");
        check("post reset lit", 32'(o10_Dout), 32'(10'h274));

        // Every data byte and every legal control byte, random forces.
        for (int i = 0; i < 256; i++)
            step(8'(i), 1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom), "sweep D");
        for (int i = 0; i < 12; i++) begin
            step(K_LIST[i], 1'b1, 1'b1, 1'b0, "sweep K-");
            step(K_LIST[i], 1'b1, 1'b1, 1'b1, "sweep K+");
        end

        // Random traffic with control requests, forces and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_step("rand reset");
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    b = K_LIST[$urandom_range(0, 11)];
                    k = 1'b1;
                end else begin
                    b = 8'($urandom);
                    k = 1'($urandom_range(0, 7) == 0);
                end
                step(b, k, 1'($urandom_range(0, 4) == 0), 1'($urandom), "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
